digit_serial_adder: RTL and testbench

//  Parametrised multi-cycle adder/subtractor. Adds WIDTH-bit operands DIGIT bits per clock

---
 rtl/digit_serial_adder_pkg.sv | 10 +
 rtl/digit_serial_adder_slice.sv | 24 ++
 rtl/digit_serial_adder.sv | 92 +++++++++
 tb/tb_digit_serial_adder.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/digit_serial_adder_pkg.sv
// digit_serial_adder_pkg: shared state encoding and sizing helpers for the digit-serial adder
package digit_serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction
  function automatic int cnt_w(input int n);
    return n <= 1 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/digit_serial_adder_slice.sv
// digit_adder_slice: combinational DIGIT-bit ripple-carry adder with carry into its top bit
module digit_adder_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);
  logic c;
  always_comb begin
    s = '0;
    c_msb = 1'b0;
    c = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      if (i == DIGIT - 1) c_msb = c;
      c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end
endmodule

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: multi-cycle add/sub, DIGIT bits per clock over a valid/ready handshake
// Define DIGIT_SERIAL_ADDER_OVF_EN to add the signed `overflow` output.
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  ,
  output logic             overflow
`endif
);
  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW = cnt_w(NDIG);
  if ((WIDTH % DIGIT) != 0 || NDIG < 1) begin : g_bad_cfg
    $error("digit_serial_adder: WIDTH must be a non-zero multiple of DIGIT");
  end
  state_t           state;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] s;
  logic             co, c_msb, last;
  logic [WIDTH+DIGIT-1:0] cat;
  digit_adder_slice #(.DIGIT(DIGIT)) u_slice (
    .a(a_q[DIGIT-1:0]),
    .b(b_q[DIGIT-1:0]),
    .ci(carry),
    .s(s),
    .co(co),
    .c_msb(c_msb)
  );
  assign in_ready = (state == IDLE) && !rst;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign last = cnt == CW'(NDIG - 1);
  // result digits enter at the MSB end so the first digit ends up at bit 0
  assign cat = {s, sum};
`ifndef DIGIT_SERIAL_ADDER_OVF_EN
  logic unused_c_msb;
  assign unused_c_msb = c_msb;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sum <= '0;
      cout <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      carry <= 1'b0;
      cnt <= '0;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
      overflow <= 1'b0;
`endif
    end else if (state == IDLE && in_valid) begin
      state <= BUSY;
      a_q <= a;
      b_q <= sub ? ~b : b;
      carry <= cin;
      cnt <= '0;
    end else if (state == BUSY) begin
      a_q <= a_q >> DIGIT;
      b_q <= b_q >> DIGIT;
      carry <= co;
      sum <= cat[WIDTH+DIGIT-1:DIGIT];
      cnt <= cnt + 1'b1;
      if (last) begin
        state <= DONE;
        cout <= co;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        overflow <= co ^ c_msb;
`endif
      end
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder: directed vectors for the 32/4 adder plus an 8/8 single-digit instance
module tb_digit_serial_adder;
  typedef struct {
    logic [31:0] a, b;
    logic        cin, sub;
    logic [31:0] s;
    logic        co, ov;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic        in_valid = 0, in_ready, cin = 0, sub = 0, out_valid, out_ready = 1, cout, busy;
  logic [31:0] a = '0, b = '0, sum;
  logic        in_valid8 = 0, in_ready8, cin8 = 0, sub8 = 0, out_valid8, out_ready8 = 1, cout8, busy8;
  logic [7:0]  a8 = '0, b8 = '0, sum8;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  logic overflow, overflow8;
`endif
  int n_cmp = 0, n_bad = 0;
  digit_serial_adder #(.WIDTH(32), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .busy(busy)
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    , .overflow(overflow)
`endif
  );
  digit_serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8),
    .cout(cout8), .busy(busy8)
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    , .overflow(overflow8)
`endif
  );
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic do_op(input vec_t v, input int idx, input bit hold);
    int lat;
    @(negedge clk);
    chk($sformatf("in_ready[%0d]", idx), 32'(in_ready), 32'd1);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    chk($sformatf("latency[%0d]", idx), 32'(lat), 32'd8);
    chk($sformatf("sum[%0d]", idx), sum, v.s);
    chk($sformatf("cout[%0d]", idx), 32'(cout), 32'(v.co));
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    chk($sformatf("overflow[%0d]", idx), 32'(overflow), 32'(v.ov));
`endif
    if (!hold) begin
      @(posedge clk);
      #1 chk($sformatf("idle_busy[%0d]", idx), 32'(busy), 32'd0);
    end
  endtask
  vec_t vt[9];
  initial begin
    bit seen;
    vt[0] = '{32'hFFFFFFFF, 32'h00000001, 0, 0, 32'h00000000, 1, 0};
    vt[1] = '{32'h00000005, 32'h00000007, 1, 1, 32'hFFFFFFFE, 0, 0};
    vt[2] = '{32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 0, 1};
    vt[3] = '{32'h12345678, 32'h9ABCDEF0, 0, 0, 32'hACF13568, 0, 0};
    vt[4] = '{32'h80000000, 32'h80000000, 0, 0, 32'h00000000, 1, 1};
    vt[5] = '{32'h00000000, 32'h00000001, 1, 1, 32'hFFFFFFFF, 0, 0};
    vt[6] = '{32'h0000000A, 32'h00000003, 1, 1, 32'h00000007, 1, 0};
    vt[7] = '{32'h80000000, 32'h00000001, 1, 1, 32'h7FFFFFFF, 1, 1};
    vt[8] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1, 0, 32'h00000000, 1, 0};
    repeat (3) @(posedge clk);
    #1 chk("in_ready_in_rst", 32'(in_ready), 32'd0);
    @(negedge clk) rst = 0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 9; i++) do_op(vt[i], i, 0);
    // DONE held with out_ready low while new operands are offered
    out_ready = 0;
    do_op(vt[2], 100, 1);
    a = 32'h11111111; b = 32'h22222222; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold_sum[%0d]", i), sum, 32'h80000000);
      chk($sformatf("hold_cout[%0d]", i), 32'(cout), 32'd0);
      chk($sformatf("hold_valid[%0d]", i), 32'(out_valid), 32'd1);
      chk($sformatf("hold_in_ready[%0d]", i), 32'(in_ready), 32'd0);
    end
    @(negedge clk) begin in_valid = 0; out_ready = 1; end
    @(posedge clk);
    #1;
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_busy", 32'(busy), 32'd0);
    // reset during BUSY discards the operation
    @(negedge clk) begin a = 32'hFFFFFFFF; b = 32'h1; cin = 0; sub = 0; in_valid = 1; end
    @(posedge clk);
    #1 in_valid = 0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1;
    @(posedge clk);
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_sum", sum, 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk) rst = 0;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1 seen |= out_valid;
    end
    chk("midrst_no_valid", 32'(seen), 32'd0);
    // single-digit instance
    @(negedge clk) begin a8 = 8'hFF; b8 = 8'h01; in_valid8 = 1; end
    @(posedge clk);
    #1 in_valid8 = 0;
    chk("w8_valid_early", 32'(out_valid8), 32'd0);
    @(posedge clk);
    #1;
    chk("w8_valid", 32'(out_valid8), 32'd1);
    chk("w8_sum", 32'(sum8), 32'h00);
    chk("w8_cout", 32'(cout8), 32'd1);
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    chk("w8_overflow", 32'(overflow8), 32'd0);
`endif
    @(posedge clk);
    #1 chk("w8_idle", 32'(in_ready8), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
